// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit helper for the BCD serial subtractor.
package bcd_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_SIX  = 4'd6;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        CPL,
        DONE
    } state_t;

    // True when the nibble is a legal decimal digit.
    function automatic logic is_bcd(input logic [3:0] digit);
        return (digit <= BCD_NINE);
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtract stage: x + (9 - y) + cin, decimal-corrected.
// Shared by the subtract pass and the ten's-complement (CPL) pass.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [3:0] y_nine;
    logic [4:0] sum;

    // Nines-complement add with +6 correction whenever the raw sum passes 9.
    always_comb begin
        y_nine = BCD_NINE - y;
        sum    = {1'b0, x} + {1'b0, y_nine} + {4'b0000, cin};
        if (sum > 5'd9) begin
            digit = sum[3:0] + BCD_SIX;
            cout  = 1'b1;
        end else begin
            digit = sum[3:0];
            cout  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor, D = A - B - bin, least-significant digit first.
// Optional sign/magnitude output enabled by `define BCD_SUB_SIGN_MAG_EN.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   d,
    output logic                  bout,
    output logic                  neg,
    output logic                  err
);

    localparam int W  = BCD_W * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    d_q;
    logic            c_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            bout_q;
    logic            err_q;

    logic [3:0]      stage_x;
    logic [3:0]      stage_y;
    logic [3:0]      stage_digit;
    logic            stage_cout;
    logic [W-1:0]    d_shift_d;
    logic            err_d;
    logic            last_digit;

    // In CPL the stage computes 0 - d digit by digit, re-reading d from its own shift register.
    always_comb begin
        if (state_q == CPL) begin
            stage_x = '0;
            stage_y = d_q[3:0];
        end else begin
            stage_x = a_q[3:0];
            stage_y = b_q[3:0];
        end
        d_shift_d = d_q >> BCD_W;
        d_shift_d[W-1 -: BCD_W] = stage_digit;
        last_digit = (cnt_q == CW'(DIGITS - 1));
    end

    // Flag any non-decimal digit in either incoming operand.
    always_comb begin
        err_d = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            err_d = err_d | ~is_bcd(a[4*i +: 4]) | ~is_bcd(b[4*i +: 4]);
        end
    end

    bcd_digit_sub u_digit (
        .x     (stage_x),
        .y     (stage_y),
        .cin   (c_q),
        .digit (stage_digit),
        .cout  (stage_cout)
    );

`ifdef BCD_SUB_SIGN_MAG_EN
    logic neg_q;
`endif

    // Control FSM plus operand/result shift registers and the decimal carry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            c_q         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bout_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        c_q        <= ~bin;
                        cnt_q      <= '0;
                        err_q      <= err_d;
                        bout_q     <= 1'b0;
                        in_ready_q <= 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
                        neg_q      <= 1'b0;
`endif
                        state_q    <= SUB;
                    end
                end
                SUB: begin
                    a_q   <= a_q >> BCD_W;
                    b_q   <= b_q >> BCD_W;
                    d_q   <= d_shift_d;
                    c_q   <= stage_cout;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_digit) begin
                        bout_q <= ~stage_cout;
`ifdef BCD_SUB_SIGN_MAG_EN
                        if (!stage_cout) begin
                            // Negative result: second pass forms 0 - d with carry preset to 1.
                            c_q     <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= CPL;
                        end else begin
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
`else
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`endif
                    end
                end
`ifdef BCD_SUB_SIGN_MAG_EN
                CPL: begin
                    d_q   <= d_shift_d;
                    c_q   <= stage_cout;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_digit) begin
                        neg_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign bout      = bout_q;
    assign err       = err_q;
`ifdef BCD_SUB_SIGN_MAG_EN
    assign neg       = neg_q;
`else
    assign neg       = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Directed bench for bcd_serial_subtractor (DIGITS=4); expectations follow
// whichever way BCD_SUB_SIGN_MAG_EN is set for the build.
module tb_bcd_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] d;
    logic        bout;
    logic        neg;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    int lat;

`ifdef BCD_SUB_SIGN_MAG_EN
    localparam int          NEG_LAT   = 8;
    localparam logic [15:0] D_1234_5K = 16'h3766;
    localparam logic [15:0] D_0_0_B1  = 16'h0001;
    localparam logic        NEG_EXP   = 1'b1;
`else
    localparam int          NEG_LAT   = 4;
    localparam logic [15:0] D_1234_5K = 16'h6234;
    localparam logic [15:0] D_0_0_B1  = 16'h9999;
    localparam logic        NEG_EXP   = 1'b0;
`endif

    bcd_serial_subtractor #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .neg       (neg),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand set, wait for the accept edge, then count edges to out_valid.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                         output int edges);
        a        = ta;
        b        = tb;
        bin      = tbin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("busy_in_ready", 32'(in_ready), 32'd0);
        edges = 0;
        while (!out_valid && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ack_out_valid", 32'(out_valid), 32'd0);
        check("ack_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_neg", 32'(neg), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        // 5000 - 1234 = 3766
        do_op(16'h5000, 16'h1234, 1'b0, lat);
        check("pos_lat", 32'(lat), 32'd4);
        check("pos_d", 32'(d), 32'h3766);
        check("pos_bout", 32'(bout), 32'd0);
        check("pos_neg", 32'(neg), 32'd0);
        check("pos_err", 32'(err), 32'd0);
        ack();

        // 1234 - 5000: negative result
        do_op(16'h1234, 16'h5000, 1'b0, lat);
        check("neg_lat", 32'(lat), 32'(NEG_LAT));
        check("neg_d", 32'(d), 32'(D_1234_5K));
        check("neg_bout", 32'(bout), 32'd1);
        check("neg_neg", 32'(neg), 32'(NEG_EXP));
        ack();

        // 0000 - 0000 - 1: wrap
        do_op(16'h0000, 16'h0000, 1'b1, lat);
        check("wrap_lat", 32'(lat), 32'(NEG_LAT));
        check("wrap_d", 32'(d), 32'(D_0_0_B1));
        check("wrap_bout", 32'(bout), 32'd1);
        check("wrap_neg", 32'(neg), 32'(NEG_EXP));
        ack();

        // 9999 - 0000, held under back-pressure with a competing in_valid
        do_op(16'h9999, 16'h0000, 1'b0, lat);
        check("max_lat", 32'(lat), 32'd4);
        check("max_d", 32'(d), 32'h9999);
        check("max_bout", 32'(bout), 32'd0);
        for (int i = 0; i < 5; i++) begin
            a        = 16'h1111;
            b        = 16'h0001;
            in_valid = 1'b1;
            tick();
            check("hold_d", 32'(d), 32'h9999);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        ack();
        tick();
        check("no_stray_op", 32'(out_valid), 32'd0);

        // Non-decimal digit in a
        do_op(16'h12A4, 16'h0001, 1'b0, lat);
        check("err_lat", 32'(lat), 32'd4);
        check("err_flag", 32'(err), 32'd1);
        ack();

        // Reset during the third digit of SUB
        a        = 16'h5000;
        b        = 16'h1234;
        bin      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_d", 32'(d), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        check("abort_neg", 32'(neg), 32'd0);

        // 0042 - 0017 = 0025 after the abort
        do_op(16'h0042, 16'h0017, 1'b0, lat);
        check("post_lat", 32'(lat), 32'd4);
        check("post_d", 32'(d), 32'h0025);
        check("post_bout", 32'(bout), 32'd0);
        check("post_err", 32'(err), 32'd0);
        ack();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
